// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : Bundles the fetch-lookup, execute-branch, comparator and
//                redirect/statistics signals of the branch resolve unit.
//                master : pipeline side (drives PCs, branch info, flags)
//                slave  : branch_resolve_unit (drives prediction, compare
//                         mode, redirect/flush, illegal pulse, counters)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if;
    // Fetch-stage BHT lookup
    logic [31:0] if_pc;
    logic        if_pred_taken;
    // Execute-stage branch
    logic        ex_valid;
    logic        ex_is_br;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    // Comparator handshake
    logic        br_less;
    logic        br_equal;
    logic        br_un;
    // Redirect and status
    logic        redirect;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        br_illegal;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    modport master (
        output if_pc, ex_valid, ex_is_br, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, br_less, br_equal,
        input  if_pred_taken, br_un, redirect, flush, redirect_pc,
               br_illegal, br_count, mispred_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_br, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, br_less, br_equal,
        output if_pred_taken, br_un, redirect, flush, redirect_pc,
               br_illegal, br_count, mispred_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Execute-stage branch resolution. Selects the comparator
//                compare mode from funct3, decides the real outcome, checks
//                it against the fetch prediction and issues a registered
//                one-cycle redirect/flush. Owns a 2-bit saturating-counter
//                BHT that serves fetch predictions, plus branch and
//                mispredict event counters.
//  Ports       : i_clk   - clock
//                i_reset - synchronous active-high reset
//                bus     - branch_resolve_unit_if.slave (see interface)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int   BHT_ENTRIES        = 64,
    parameter logic BR_UN_SIGNED_LEVEL = 1'b1
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    branch_resolve_unit_if.slave bus
);

    localparam int         IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [1:0] C_BHT_INIT = 2'b01;   // weakly not-taken

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_bht [BHT_ENTRIES];
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_br_illegal;
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_resolve;
    logic             w_taken;
    logic             w_legal;
    logic             w_mispred;
    logic [1:0]       w_bht_cur;
    logic [1:0]       w_bht_next;
    logic             w_unused_pc_bits;

    assign w_if_idx = bus.if_pc[IDX_W+1:2];
    assign w_ex_idx = bus.ex_pc[IDX_W+1:2];

    // PC bits outside the BHT index have no role in the lookup.
    assign w_unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

    // A branch arriving alongside a redirect is in the shadow being flushed.
    assign w_resolve = bus.ex_valid & bus.ex_is_br & ~r_redirect;

    // funct3[1] separates the unsigned compares (BLTU/BGEU) from the rest.
    assign bus.br_un = bus.ex_funct3[1] ? ~BR_UN_SIGNED_LEVEL : BR_UN_SIGNED_LEVEL;

    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        case (bus.ex_funct3)
            3'b000:          w_taken = bus.br_equal;
            3'b001:          w_taken = ~bus.br_equal;
            3'b100, 3'b110:  w_taken = bus.br_less;
            3'b101, 3'b111:  w_taken = ~bus.br_less;
            default: begin
                // Illegal encodings behave as not-taken.
                w_taken = 1'b0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_mispred = w_resolve & (w_taken != bus.ex_pred_taken);

    // Saturating 2-bit counter step for the resolving branch's entry.
    assign w_bht_cur = r_bht[w_ex_idx];

    always_comb begin
        w_bht_next = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // BHT: lookup is combinational, so a same-cycle update of the same
    // entry is seen by fetch only from the next cycle on.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= C_BHT_INIT;
            end
        end else if (w_resolve && w_legal) begin
            r_bht[w_ex_idx] <= w_bht_next;
        end
    end

    assign bus.if_pred_taken = r_bht[w_if_idx][1];

    // ------------------------------------------------------------------
    // Redirect, illegal pulse and event counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_redirect      <= 1'b0;
            r_redirect_pc   <= 32'd0;
            r_br_illegal    <= 1'b0;
            r_br_count      <= 32'd0;
            r_mispred_count <= 32'd0;
        end else begin
            r_redirect   <= w_mispred;
            r_br_illegal <= w_resolve & ~w_legal;
            // Restart address holds between redirects; pc+4 wraps mod 2^32.
            if (w_mispred) begin
                r_redirect_pc <= w_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
            end
            if (w_resolve && w_legal) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_mispred) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign bus.redirect      = r_redirect;
    assign bus.flush         = r_redirect;
    assign bus.redirect_pc   = r_redirect_pc;
    assign bus.br_illegal    = r_br_illegal;
    assign bus.br_count      = r_br_count;
    assign bus.mispred_count = r_mispred_count;

endmodule

`default_nettype wire
